data_mem_responder: RTL and testbench
=====================================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the core's load/store data path. Accepts one load or store request at a time from the register file.
//  Holds it for a fixed, parameterised latency, then performs the access on an internal byte RAM.
//  Returns a one-cycle response: load data, or store acknowledge.
//  Drives stall so the core freezes its PC while an access is in flight.
// PARAMETERS
//  ADDR_W  8    request address width
//  DEPTH   256  implemented bytes; must be <= 2**ADDR_W
//  RD_LAT  2    load latency in cycles, >=1
//  WR_LAT  1    store latency in cycles, >=1
// PORTS
//  clk        in   1       single clock; all state updates on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  req_valid  in   1       core presents a request
//  req_we     in   1       1 = store, 0 = load
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   8       store data (the core's storData)
//  req_ready  out  1       responder can accept; high only in IDLE
//  rsp_valid  out  1       one-cycle pulse: access complete
//  rsp_rdata  out  8       load result (the core's loadData); held between responses
//  rsp_err    out  1       qualifies rsp_valid; address >= DEPTH
//  stall      out  1       high while state != IDLE
// BEHAVIOUR
//  Reset
//   - rst_n low asynchronously forces state IDLE, counter 0, latched request 0.
//   - Outputs during reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, stall=0.
//   - RAM contents are NOT reset.
//   - Reset mid-access: access is abandoned. An in-flight store is dropped and RAM is unchanged. No response is issued.
//  Accept
//   - A request is accepted on a posedge where req_valid && req_ready.
//   - req_we, req_addr and req_wdata are latched at that edge. The core may change them afterwards.
//  FSM: IDLE, WAIT, RESP
//   - IDLE: accept. LAT = req_we ? WR_LAT : RD_LAT.
//     - LAT==1: perform access at the accept edge and go to RESP.
//     - Else: cnt <= LAT-1 and go to WAIT.
//   - WAIT: on each edge, if cnt==1 perform access and go to RESP; otherwise cnt <= cnt-1.
//   - RESP: rsp_valid=1 for exactly one cycle, then IDLE. The core has no backpressure.
//   - rsp_valid is high exactly LAT cycles after the accept cycle.
//   - Minimum spacing between accepts is LAT+1 cycles.
//  Access
//   - Load: rsp_rdata <= mem[addr].
//   - Store: mem[addr] <= wdata, and rsp_rdata is unchanged.
//   - Read and write never coincide, because only one request is in flight.
//  Out of range (addr >= DEPTH)
//   - Store is discarded.
//   - Load returns rsp_rdata=8'h00.
//   - rsp_err=1 alongside rsp_valid. rsp_err is otherwise 0.
//  Other rules
//   - stall = (state != IDLE). It is combinational from state only, with no path from req_* inputs.
//   - req_valid in WAIT or RESP is ignored, not queued. The core must hold it until req_ready.
//   - Counter width is $clog2(max(RD_LAT,WR_LAT)+1).
//   - Address width is truncated to $clog2(DEPTH) only after the range check.
// STRUCTURE
//  Shared package (instr_pack):
//   - typedef enum logic [1:0] {MEM_IDLE, MEM_WAIT, MEM_RESP} mem_state_e
//   - localparam DATA_W = 8
//  One sub-module: data_mem_array.
//   - Synchronous single-port RAM, DEPTH x 8.
//   - Ports: clk, we, re, addr, wdata, rdata.
//   - No reset.
//  The FSM, counter, request latch and range check live in this module.
// TESTING
//  1. Store then load, default latencies:
//     - Store 8'hA5 @ 8'h10: rsp_valid 1 cycle after accept, stall high 1 cycle.
//     - Load @ 8'h10: rsp_valid 2 cycles after accept with rsp_rdata=8'hA5.
//  2. Input change after accept:
//     - Load @ 8'h20, then drive req_addr=8'h30 during WAIT.
//     - Response returns mem[8'h20], not mem[8'h30].
//  3. Back-to-back requests:
//     - req_valid held high for 3 loads.
//     - req_ready is low in WAIT and RESP; each load is accepted RD_LAT+1 cycles apart, with no lost or duplicate rsp_valid.
//  4. Out of range, with DEPTH=128:
//     - Store 8'h77 @ 8'h80: rsp_err=1 and the RAM is unchanged.
//     - Load @ 8'h80: rsp_rdata=8'h00, rsp_err=1.
//  5. Reset mid-store:
//     - WR_LAT=3; store 8'h3C @ 8'h05; pulse rst_n low during WAIT.
//     - Outputs go to reset values immediately with no rsp_valid.
//     - A later load @ 8'h05 returns the old value.
//  6. RD_LAT=1, WR_LAT=4 sweep:
//     - Load/store mix: each response arrives at exactly its LAT.
//     - rsp_rdata is unchanged across stores.

Source files
------------

// File: rtl/instr_pack.sv
// Shared types for the core's load/store data path.
// Holds the responder FSM encoding and the data byte width.
package instr_pack;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    MEM_IDLE,
    MEM_WAIT,
    MEM_RESP
  } mem_state_e;

endpackage

// File: rtl/data_mem_array.sv
// Synchronous single-port byte RAM behind the data memory responder.
// There is no reset, and the read register only updates when re is high.
module data_mem_array
  import instr_pack::*;
#(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder for core loads and stores. It takes one request at a time and holds it
// for a fixed latency. It then accesses the byte RAM and pulses a one-cycle response.
module data_mem_responder
  import instr_pack::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              stall
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);
  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] RD_CNT  = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_CNT  = CNT_W'(WR_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              rdRam_q, rdRam_d;

  logic              access;
  logic              accWe;
  logic              inRange;
  logic [ADDR_W-1:0] accAddr;
  logic [DATA_W-1:0] accWdata;
  logic              ramWe;
  logic              ramRe;
  logic [DATA_W-1:0] ramRdata;

  // A latency of 1 accesses at the accept edge, so the access takes its operands from the live request.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    rdRam_d  = rdRam_q;
    access   = 1'b0;
    accWe    = we_q;
    accAddr  = addr_q;
    accWdata = wdata_q;

    case (state_q)
      MEM_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          accWe    = req_we;
          accAddr  = req_addr;
          accWdata = req_wdata;
          if ((req_we ? WR_LAT : RD_LAT) == 1) begin
            access  = 1'b1;
            state_d = MEM_RESP;
          end else begin
            cnt_d   = req_we ? WR_CNT : RD_CNT;
            state_d = MEM_WAIT;
          end
        end
      end
      MEM_WAIT: begin
        if (cnt_q == CNT_ONE) begin
          access  = 1'b1;
          state_d = MEM_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      MEM_RESP: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase

    inRange = ({1'b0, accAddr} < DEPTH_L);
    if (access) begin
      err_d = !inRange;
      if (!accWe) rdRam_d = inRange;
    end
    ramWe = rst_n && access && accWe && inRange;
    ramRe = rst_n && access && !accWe && inRange;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MEM_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdRam_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdRam_q <= rdRam_d;
    end
  end

  data_mem_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (ramWe),
    .re    (ramRe),
    .addr  (accAddr[IDX_W-1:0]),
    .wdata (accWdata),
    .rdata (ramRdata)
  );

  // Zero covers both the post-reset value and an out-of-range load; stores leave the select alone.
  assign rsp_rdata = rdRam_q ? ramRdata : '0;
  assign req_ready = (state_q == MEM_IDLE);
  assign stall     = (state_q != MEM_IDLE);
  assign rsp_valid = (state_q == MEM_RESP);
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder, using three instances with different latency and depth settings.
// Expected latencies and data are hand-derived constants.
module tb_data_mem_responder;

  logic            clk;
  logic [2:0]      rstN;
  logic [2:0]      reqValid;
  logic [2:0]      reqWe;
  logic [2:0][7:0] reqAddr;
  logic [2:0][7:0] reqWdata;
  logic [2:0]      reqReady;
  logic [2:0]      rspValid;
  logic [2:0][7:0] rspRdata;
  logic [2:0]      rspErr;
  logic [2:0]      stall;

  int checks = 0;
  int passes = 0;

  data_mem_responder u_dut0 (
    .clk(clk), .rst_n(rstN[0]), .req_valid(reqValid[0]), .req_we(reqWe[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_ready(reqReady[0]),
    .rsp_valid(rspValid[0]), .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0]), .stall(stall[0])
  );

  data_mem_responder #(.ADDR_W(8), .DEPTH(128), .RD_LAT(2), .WR_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rstN[1]), .req_valid(reqValid[1]), .req_we(reqWe[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_ready(reqReady[1]),
    .rsp_valid(rspValid[1]), .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1]), .stall(stall[1])
  );

  data_mem_responder #(.ADDR_W(8), .DEPTH(256), .RD_LAT(1), .WR_LAT(4)) u_dut2 (
    .clk(clk), .rst_n(rstN[2]), .req_valid(reqValid[2]), .req_we(reqWe[2]),
    .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]), .req_ready(reqReady[2]),
    .rsp_valid(rspValid[2]), .rsp_rdata(rspRdata[2]), .rsp_err(rspErr[2]), .stall(stall[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One request issued from IDLE. The request inputs are scrambled right after the accept edge.
  task automatic applyStimulus(input int u, input logic we, input logic [7:0] addr,
                               input logic [7:0] wd, input logic [7:0] postAddr,
                               output int lat, output int stallCyc,
                               output logic [7:0] rd, output logic err);
    reqValid[u] = 1'b1;
    reqWe[u]    = we;
    reqAddr[u]  = addr;
    reqWdata[u] = wd;
    tick();
    reqValid[u] = 1'b0;
    reqWe[u]    = ~we;
    reqAddr[u]  = postAddr;
    reqWdata[u] = ~wd;
    lat      = 1;
    stallCyc = int'(stall[u]);
    while (!rspValid[u] && lat < 20) begin
      tick();
      lat++;
      stallCyc += int'(stall[u]);
    end
    rd  = rspRdata[u];
    err = rspErr[u];
    tick();
    stallCyc += int'(stall[u]);
  endtask

  task automatic doAccess(input string tag, input int u, input logic we, input logic [7:0] addr,
                          input logic [7:0] wd, input logic [7:0] postAddr,
                          input int expLat, input logic [7:0] expRd, input logic expErr);
    int lat, stallCyc;
    logic [7:0] rd;
    logic err;
    applyStimulus(u, we, addr, wd, postAddr, lat, stallCyc, rd, err);
    checkOutput({tag, " latency"}, lat, expLat);
    checkOutput({tag, " stall cycles"}, stallCyc, expLat);
    checkOutput({tag, " rdata"}, {24'h0, rd}, {24'h0, expRd});
    checkOutput({tag, " err"}, {31'h0, err}, {31'h0, expErr});
  endtask

  initial begin
    int acceptCyc [3];
    int nAcc;
    int busyReady;
    logic [7:0] got [$];
    logic [7:0] b2bAddr [3];

    rstN     = 3'b000;
    reqValid = '0;
    reqWe    = '0;
    reqAddr  = '0;
    reqWdata = '0;
    #2;
    checkOutput("reset req_ready", {31'h0, reqReady[0]}, 32'h1);
    checkOutput("reset rsp_valid", {31'h0, rspValid[0]}, 32'h0);
    checkOutput("reset rsp_rdata", {24'h0, rspRdata[0]}, 32'h0);
    checkOutput("reset rsp_err",   {31'h0, rspErr[0]},   32'h0);
    checkOutput("reset stall",     {31'h0, stall[0]},    32'h0);
    tick();
    tick();
    rstN = 3'b111;
    tick();

    $display("[TB] store/load with default latencies");
    doAccess("t1 store", 0, 1'b1, 8'h10, 8'hA5, 8'h00, 1, 8'h00, 1'b0);
    doAccess("t1 load",  0, 1'b0, 8'h10, 8'h00, 8'h33, 2, 8'hA5, 1'b0);

    $display("[TB] input change after accept");
    doAccess("t2 store20", 0, 1'b1, 8'h20, 8'h11, 8'h30, 1, 8'hA5, 1'b0);
    doAccess("t2 store30", 0, 1'b1, 8'h30, 8'h22, 8'h20, 1, 8'hA5, 1'b0);
    doAccess("t2 load20",  0, 1'b0, 8'h20, 8'h00, 8'h30, 2, 8'h11, 1'b0);

    $display("[TB] back-to-back loads");
    b2bAddr[0] = 8'h10;
    b2bAddr[1] = 8'h20;
    b2bAddr[2] = 8'h30;
    nAcc = 0;
    busyReady = 0;
    reqValid[0] = 1'b1;
    reqWe[0]    = 1'b0;
    reqAddr[0]  = b2bAddr[0];
    for (int cyc = 0; cyc < 14; cyc++) begin
      automatic logic accNow = reqValid[0] && reqReady[0];
      if (accNow && nAcc < 3) begin
        acceptCyc[nAcc] = cyc;
        nAcc++;
      end
      if (stall[0] && reqReady[0]) busyReady++;
      tick();
      if (accNow) begin
        if (nAcc < 3) reqAddr[0] = b2bAddr[nAcc];
        else reqValid[0] = 1'b0;
      end
      if (rspValid[0]) got.push_back(rspRdata[0]);
    end
    reqValid[0] = 1'b0;
    checkOutput("t3 accept count", nAcc, 3);
    checkOutput("t3 spacing 0-1", acceptCyc[1] - acceptCyc[0], 3);
    checkOutput("t3 spacing 1-2", acceptCyc[2] - acceptCyc[1], 3);
    checkOutput("t3 ready while busy", busyReady, 0);
    checkOutput("t3 response count", got.size(), 3);
    checkOutput("t3 data0", {24'h0, (got.size() > 0) ? got[0] : 8'hxx}, 32'hA5);
    checkOutput("t3 data1", {24'h0, (got.size() > 1) ? got[1] : 8'hxx}, 32'h11);
    checkOutput("t3 data2", {24'h0, (got.size() > 2) ? got[2] : 8'hxx}, 32'h22);

    $display("[TB] out of range with DEPTH=128");
    doAccess("t4 store00", 1, 1'b1, 8'h00, 8'h5A, 8'h80, 3, 8'h00, 1'b0);
    doAccess("t4 store80", 1, 1'b1, 8'h80, 8'h77, 8'h00, 3, 8'h00, 1'b1);
    doAccess("t4 load00",  1, 1'b0, 8'h00, 8'h00, 8'h80, 2, 8'h5A, 1'b0);
    doAccess("t4 load80",  1, 1'b0, 8'h80, 8'h00, 8'h00, 2, 8'h00, 1'b1);
    doAccess("t4 store7F", 1, 1'b1, 8'h7F, 8'h66, 8'h80, 3, 8'h00, 1'b0);
    doAccess("t4 load7F",  1, 1'b0, 8'h7F, 8'h00, 8'h80, 2, 8'h66, 1'b0);

    $display("[TB] reset during store");
    doAccess("t5 store old", 1, 1'b1, 8'h05, 8'hC3, 8'h00, 3, 8'h66, 1'b0);
    reqValid[1] = 1'b1;
    reqWe[1]    = 1'b1;
    reqAddr[1]  = 8'h05;
    reqWdata[1] = 8'h3C;
    tick();
    reqValid[1] = 1'b0;
    tick();
    checkOutput("t5 stall in wait", {31'h0, stall[1]}, 32'h1);
    rstN[1] = 1'b0;
    #1;
    checkOutput("t5 rst req_ready", {31'h0, reqReady[1]}, 32'h1);
    checkOutput("t5 rst rsp_valid", {31'h0, rspValid[1]}, 32'h0);
    checkOutput("t5 rst rsp_rdata", {24'h0, rspRdata[1]}, 32'h0);
    checkOutput("t5 rst rsp_err",   {31'h0, rspErr[1]},   32'h0);
    checkOutput("t5 rst stall",     {31'h0, stall[1]},    32'h0);
    tick();
    checkOutput("t5 no rsp in reset", {31'h0, rspValid[1]}, 32'h0);
    rstN[1] = 1'b1;
    tick();
    tick();
    checkOutput("t5 no rsp after reset", {31'h0, rspValid[1]}, 32'h0);
    doAccess("t5 load old", 1, 1'b0, 8'h05, 8'h00, 8'h00, 2, 8'hC3, 1'b0);

    $display("[TB] RD_LAT=1 WR_LAT=4 mix");
    doAccess("t6 store01", 2, 1'b1, 8'h01, 8'h44, 8'h02, 4, 8'h00, 1'b0);
    doAccess("t6 load01",  2, 1'b0, 8'h01, 8'h00, 8'h02, 1, 8'h44, 1'b0);
    doAccess("t6 store02", 2, 1'b1, 8'h02, 8'h55, 8'h01, 4, 8'h44, 1'b0);
    doAccess("t6 load02",  2, 1'b0, 8'h02, 8'h00, 8'h01, 1, 8'h55, 1'b0);
    doAccess("t6 store01b", 2, 1'b1, 8'h01, 8'h66, 8'h02, 4, 8'h55, 1'b0);
    doAccess("t6 load01b", 2, 1'b0, 8'h01, 8'h00, 8'h02, 1, 8'h66, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
